fifo_wr_arb_cntrl: RTL and testbench
====================================

FIFO_WR_ARB_CNTRL -- requirements
Module: fifo_wr_arb_cntrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of every write data port.
REQ-002 Parameter NUM_OF_REGS, default 8, SHALL set memory depth; legal value is 8 only, matching 3-bit addresses.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 req0 / req1  in  1 each  write request from requester 0 / 1.
REQ-006 wdata0 / wdata1  in  DATA_WIDTH each  write data from requester 0 / 1.
REQ-007 rd_en  in  1  pop request; head entry is consumed at the clock edge.
REQ-008 gnt0 / gnt1  out  1 each  write grant, combinational, one-hot or zero.
REQ-009 wclkEn  out  1  memory write enable.
REQ-010 waddr / raddr  out  3 each  memory write / read address.
REQ-011 wdata  out  DATA_WIDTH  muxed data of the granted requester; 0 when no grant.
REQ-012 full / empty  out  1 each  occupancy flags, registered-state derived.
REQ-013 ovf  out  1  sticky flag: a request was refused because the buffer was full.

Function
REQ-014 Write pointer and read pointer SHALL each be 4 bits: 3 address bits plus 1 wrap bit, incrementing modulo 16.
REQ-015 waddr SHALL equal wr_ptr[2:0], and raddr SHALL equal rd_ptr[2:0].
REQ-016 empty SHALL be 1 when wr_ptr == rd_ptr; full SHALL be 1 when address bits are equal and wrap bits differ.
REQ-017 Arbitration SHALL be round-robin with a 1-bit priority flop: with both requests present and not full, grant the priority holder.
REQ-018 After any granted write, priority SHALL pass to the other requester; with no grant, priority SHALL hold.
REQ-019 A single request SHALL be granted regardless of priority when not full.
REQ-020 When full=1, gnt0, gnt1 and wclkEn SHALL be 0, and wr_ptr SHALL hold.
REQ-021 wclkEn SHALL be gnt0|gnt1; wr_ptr SHALL increment by 1 at the edge when wclkEn=1.
REQ-022 rd_ptr SHALL increment at the edge when rd_en=1 and empty=0; rd_en while empty SHALL be ignored.
REQ-023 Simultaneous write and read: both pointers advance independently; full and empty use pre-edge state, so when full the read proceeds and the write is refused.
REQ-024 ovf SHALL set at the edge where (req0|req1)&full=1, and SHALL clear only on reset.
REQ-025 Latency: a granted write is visible on the memory read port the cycle after the edge; flags update at that same edge.

Reset
REQ-026 RST=0 SHALL asynchronously clear wr_ptr, rd_ptr, priority (to requester 0) and ovf.
REQ-027 During reset, the outputs SHALL be: empty=1, full=0, grants=0, wclkEn=0, waddr=raddr=0, wdata=0.
REQ-028 Reset asserted mid-operation SHALL discard all entries; memory contents are don't-care, since the pointers define validity.

Configuration
REQ-029 Macro FIFO_WR_ARB_CNT_EN defined: add output occupancy (4 bits) = wr_ptr - rd_ptr modulo 16, with range 0..8 and reset value 0.
REQ-030 Macro undefined: the occupancy port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package fifo_arb_pkg SHALL hold ADDR_WIDTH=3, PTR_WIDTH=4, and the requester-index typedef (REQ0/REQ1).
REQ-032 Two-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: req[1:0], en, priority; output: gnt[1:0]).
REQ-033 Pointer, flag, ovf and priority flops SHALL reside in fifo_wr_arb_cntrl.

Verification
REQ-034 Reset, then req0=1 with wdata0=0xA5 for one cycle -> gnt0=1, wclkEn=1, waddr=0; next cycle empty=0, raddr=0.
REQ-035 req0=req1=1 for 4 cycles from reset -> grants alternate 0,1,0,1 and waddr runs 0,1,2,3.
REQ-036 8 writes with no reads -> full=1 and wr_ptr=8; a 9th request -> no grant and ovf=1 (sticky).
REQ-037 While full, rd_en=1 and req1=1 in the same cycle -> read consumes raddr 0, write refused; next cycle full=0 and occupancy=7 (macro on).
REQ-038 rd_en=1 while empty -> rd_ptr unchanged, empty stays 1; 20 write/read pairs -> pointers wrap past 15 to 0 with no false full or empty.
REQ-039 Assert RST after 5 writes -> immediately empty=1, full=0, ovf=0, gnt=0; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared widths and requester index type for the arbitrated FIFO write controller.
package fifo_arb_pkg;

  localparam int ADDR_WIDTH = 3;
  localparam int PTR_WIDTH  = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_e;

  // Round-robin hand-off: the requester that just wrote yields to the other one.
  function automatic req_idx_e other_req(input req_idx_e idx);
    return (idx == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_cntrl_if.sv
// Handshake bundle between two write requesters / memory and the controller.
// The occupancy signal exists only when FIFO_WR_ARB_CNT_EN is defined.
interface fifo_wr_arb_cntrl_if #(
  parameter int DATA_WIDTH = 8
);
  import fifo_arb_pkg::*;

  logic                  req0;
  logic                  req1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  rd_en;
  logic                  gnt0;
  logic                  gnt1;
  logic                  wclkEn;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  full;
  logic                  empty;
  logic                  ovf;
`ifdef FIFO_WR_ARB_CNT_EN
  logic [PTR_WIDTH-1:0]  occupancy;
`endif

  modport master (
    output req0, req1, wdata0, wdata1, rd_en,
    input  gnt0, gnt1, wclkEn, waddr, raddr, wdata, full, empty,
`ifdef FIFO_WR_ARB_CNT_EN
    input  occupancy,
`endif
    input  ovf
  );

  modport slave (
    input  req0, req1, wdata0, wdata1, rd_en,
    output gnt0, gnt1, wclkEn, waddr, raddr, wdata, full, empty,
`ifdef FIFO_WR_ARB_CNT_EN
    output occupancy,
`endif
    output ovf
  );

endinterface

// File: rtl/fifo_wr_arb_cntrl_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the priority holder.
module rr_arb2
  import fifo_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  req_idx_e   prio,
  output logic [1:0] gnt
);

  // Combinational one-hot grant, forced to zero while disabled.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio == REQ0) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/fifo_wr_arb_cntrl.sv
// Write-side controller of an 8-entry FIFO shared by two round-robin requesters.
// Optional occupancy output is enabled by defining FIFO_WR_ARB_CNT_EN.
module fifo_wr_arb_cntrl
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_OF_REGS = 8
) (
  input logic                CLK,
  input logic                RST,
  fifo_wr_arb_cntrl_if.slave bus
);

  // With depth 8 a pointer gap of 8 is exactly "address equal, wrap bit different".
  localparam logic [PTR_WIDTH-1:0] DEPTH = PTR_WIDTH'(NUM_OF_REGS);

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  req_idx_e              prio_q, prio_d;
  logic                  ovf_q, ovf_d;
  logic [PTR_WIDTH-1:0]  fill_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  arb_en_s;
  logic                  wclken_s;
  logic                  rd_fire_s;
  logic [1:0]            gnt_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  assign fill_s    = wr_ptr_q - rd_ptr_q;
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (fill_s == DEPTH);
  // Grants are combinational, so they are also masked while reset is held.
  assign arb_en_s  = ~full_s & RST;
  assign wclken_s  = |gnt_s;
  assign rd_fire_s = bus.rd_en & ~empty_s;

  rr_arb2 u_rr_arb2 (
    .req  ({bus.req1, bus.req0}),
    .en   (arb_en_s),
    .prio (prio_q),
    .gnt  (gnt_s)
  );

  // Write data of the granted requester, zero when nobody is granted.
  always_comb begin
    wdata_s = {DATA_WIDTH{1'b0}};
    case (gnt_s)
      2'b01:   wdata_s = bus.wdata0;
      2'b10:   wdata_s = bus.wdata1;
      default: wdata_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Next-state for pointers, priority and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    ovf_d    = ovf_q;
    if (wclken_s) begin
      wr_ptr_d = wr_ptr_q + 4'd1;
      prio_d   = other_req(gnt_s[1] ? REQ1 : REQ0);
    end else begin
      wr_ptr_d = wr_ptr_q;
      prio_d   = prio_q;
    end
    if (rd_fire_s) begin
      rd_ptr_d = rd_ptr_q + 4'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if ((bus.req0 | bus.req1) & full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State flops, cleared asynchronously by the active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      prio_q   <= REQ0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      prio_q   <= prio_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.gnt0   = gnt_s[0];
  assign bus.gnt1   = gnt_s[1];
  assign bus.wclkEn = wclken_s;
  assign bus.waddr  = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bus.raddr  = rd_ptr_q[ADDR_WIDTH-1:0];
  assign bus.wdata  = wdata_s;
  assign bus.full   = full_s;
  assign bus.empty  = empty_s;
  assign bus.ovf    = ovf_q;
`ifdef FIFO_WR_ARB_CNT_EN
  assign bus.occupancy = fill_s;
`endif

endmodule

// File: tb/tb_fifo_wr_arb_cntrl.sv
// Scoreboard bench for fifo_wr_arb_cntrl: the bench acts as the FIFO memory and
// checks every output each cycle against a small reference model.
module tb_fifo_wr_arb_cntrl;

  logic clk;
  logic rst;

  fifo_wr_arb_cntrl_if #(.DATA_WIDTH(8)) bif ();

  fifo_wr_arb_cntrl #(
    .DATA_WIDTH  (8),
    .NUM_OF_REGS (8)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec;
  int         n_err;
  logic [3:0] m_wr;
  logic [3:0] m_rd;
  logic       m_prio;
  logic       m_ovf;
  logic [7:0] mem [8];
  logic [7:0] sb [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [7:0] d0,
                       input logic [7:0] d1, input logic rd);
    bif.req0   = r0;
    bif.req1   = r1;
    bif.wdata0 = d0;
    bif.wdata1 = d1;
    bif.rd_en  = rd;
  endtask

  // One clock: drive, check outputs at the falling edge, advance the model at the rising edge.
  task automatic run_cycle(input logic r0, input logic r1, input logic [7:0] d0,
                           input logic [7:0] d1, input logic rd);
    logic [1:0] g;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_wdata;
    logic [7:0] rd_exp;
    drive(r0, r1, d0, d1, rd);
    @(negedge clk);
    e_empty = (m_wr == m_rd);
    e_full  = (m_wr[2:0] == m_rd[2:0]) && (m_wr[3] != m_rd[3]);
    g = 2'b00;
    if (!e_full) begin
      if (r0 && r1) g = m_prio ? 2'b10 : 2'b01;
      else          g = {r1, r0};
    end
    e_wdata = g[0] ? d0 : (g[1] ? d1 : 8'h00);
    check_val("gnt0",   32'(bif.gnt0),   32'(g[0]));
    check_val("gnt1",   32'(bif.gnt1),   32'(g[1]));
    check_val("wclkEn", 32'(bif.wclkEn), 32'(|g));
    check_val("wdata",  32'(bif.wdata),  32'(e_wdata));
    check_val("waddr",  32'(bif.waddr),  32'(m_wr[2:0]));
    check_val("raddr",  32'(bif.raddr),  32'(m_rd[2:0]));
    check_val("empty",  32'(bif.empty),  32'(e_empty));
    check_val("full",   32'(bif.full),   32'(e_full));
    check_val("ovf",    32'(bif.ovf),    32'(m_ovf));
`ifdef FIFO_WR_ARB_CNT_EN
    check_val("occupancy", 32'(bif.occupancy), 32'(4'(m_wr - m_rd)));
`endif
    if (rd && !e_empty) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        rd_exp = sb.pop_front();
        check_val("rdata", 32'(mem[bif.raddr]), 32'(rd_exp));
      end
    end
    if (g != 2'b00) sb.push_back(e_wdata);
    if (bif.wclkEn) mem[bif.waddr] = bif.wdata;
    @(posedge clk);
    if (g != 2'b00) begin
      m_wr   = m_wr + 4'd1;
      m_prio = g[0];
    end
    if (rd && !e_empty) m_rd = m_rd + 4'd1;
    if ((r0 || r1) && e_full) m_ovf = 1'b1;
    #1;
  endtask

  // Asynchronous reset with all requests raised: outputs must collapse at once.
  task automatic apply_reset();
    drive(1'b1, 1'b1, 8'h3C, 8'hC3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_gnt0",   32'(bif.gnt0),   32'd0);
    check_val("rst_gnt1",   32'(bif.gnt1),   32'd0);
    check_val("rst_wclkEn", 32'(bif.wclkEn), 32'd0);
    check_val("rst_wdata",  32'(bif.wdata),  32'd0);
    check_val("rst_empty",  32'(bif.empty),  32'd1);
    check_val("rst_full",   32'(bif.full),   32'd0);
    check_val("rst_ovf",    32'(bif.ovf),    32'd0);
    check_val("rst_waddr",  32'(bif.waddr),  32'd0);
    check_val("rst_raddr",  32'(bif.raddr),  32'd0);
`ifdef FIFO_WR_ARB_CNT_EN
    check_val("rst_occupancy", 32'(bif.occupancy), 32'd0);
`endif
    m_wr   = 4'd0;
    m_rd   = 4'd0;
    m_prio = 1'b0;
    m_ovf  = 1'b0;
    sb.delete();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic       r0;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    apply_reset();

    // Single write, then visible, then read back.
    run_cycle(1'b1, 1'b0, 8'hA5, 8'h00, 1'b0);
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Contended writes alternate, then single writes fill the buffer.
    apply_reset();
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 8'(8'h10 + i), 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(i[0] == 1'b0, i[0] == 1'b1, 8'(8'h30 + i), 8'(8'h40 + i), 1'b0);
    run_cycle(1'b1, 1'b0, 8'h77, 8'h00, 1'b0);
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Read while full with a competing write, then drain and over-read.
    run_cycle(1'b0, 1'b1, 8'h00, 8'h99, 1'b1);
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Write/read pairs carry both pointers past the wrap.
    for (int i = 0; i < 20; i++) begin
      d  = 8'($urandom);
      r0 = 1'($urandom);
      run_cycle(r0, ~r0, d, ~d, 1'b1);
    end
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Reset mid-operation discards entries and restores priority to requester 0.
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 8'(8'h50 + i), 8'h00, 1'b0);
    apply_reset();
    run_cycle(1'b1, 1'b1, 8'hE1, 8'hE2, 1'b0);
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
